aes_block_packer: RTL and testbench
===================================

# aes_block_packer

Upstream framing stage for the `aes_encryption` core. Accepts a byte-oriented 32-bit AXI-stream message, packs it into 128-bit AES blocks, and applies PKCS#7 padding to the final block. Emits the 128-bit stream that drives `aes_in_tdata/tvalid/tlast/tready` of the encryption core.

## Interface
- `PAD_ENABLE`, default 1: 1 = PKCS#7 padding; 0 = zero-fill the final partial block and emit no extra pad block.
- `clk` input 1: single clock; all logic on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `s_tdata` input 32: message bytes; byte 0 (earliest) = `[31:24]`.
- `s_tkeep` input 4: byte valid; `[3]` qualifies byte 0.
- `s_tvalid` input 1: input beat valid.
- `s_tlast` input 1: last beat of the message.
- `s_tready` output 1: input beat accepted when `s_tvalid && s_tready`.
- `m_tdata` output 128: AES block; first message byte at `[127:120]`.
- `m_tvalid` output 1: block valid.
- `m_tlast` output 1: final block of the message.
- `m_tready` input 1: downstream (encryption core `aes_in_tready`) accepts the block.
- `err` output 1: sticky protocol-error flag.

## Operation
- Internal state: 128-bit block register, 5-bit byte count `cnt` (0..16), and FSM {FILL, SEND, PAD}.
- FILL: `s_tready`=1. On each accepted beat, write the valid bytes at byte offset `cnt` and add the popcount of `s_tkeep` to `cnt`.
  - Not last, `cnt` reaches 16: go to SEND, `m_tlast`=0.
  - Last, resulting `cnt`<16:
    - PAD_ENABLE=1: fill bytes `cnt..15` with value `16-cnt`.
    - PAD_ENABLE=0: fill bytes `cnt..15` with 0x00.
    - Then go to SEND, `m_tlast`=1.
  - Last, resulting `cnt`==16:
    - PAD_ENABLE=1: go to SEND, `m_tlast`=0, set `pad_pending`.
    - PAD_ENABLE=0: go to SEND, `m_tlast`=1.
- SEND: `m_tvalid`=1, `s_tready`=0. On `m_tready`:
  - `pad_pending`: go to PAD.
  - Otherwise: clear `cnt` and the block register, go to FILL.
- PAD: `m_tdata`={16{8'h10}}, `m_tvalid`=1, `m_tlast`=1. On `m_tready`: clear `pad_pending` and `cnt`, go to FILL.
- Legal `s_tkeep` values:
  - Non-last beat: 4'b1111 only.
  - Last beat: 4'b1000, 4'b1100, 4'b1110 or 4'b1111.
  - A message is therefore 4k+n bytes, and a beat never straddles a block boundary.
- Illegal `s_tkeep` (including 4'b0000): set `err`, which stays set until reset. Process the beat as 4'b1111.
- `s_tvalid` low in FILL: hold all state; there is no timeout.

## Timing
- Reset (while `reset`=1 and on the following cycle):
  - FSM=FILL, `cnt`=0, `pad_pending`=0.
  - `m_tvalid`=0, `m_tlast`=0, `m_tdata`=0, `err`=0.
  - `s_tready`=0 while `reset`=1; `s_tready`=1 from the first cycle after release.
- Latency: `m_tvalid` rises in the cycle after the handshake of the block-completing beat.
- Throughput: 4 input beats + 1 SEND cycle = 5 cycles per full block with `m_tready` held high. PAD adds 1 cycle.
- `m_tdata` and `m_tlast` are registered and stable while `m_tvalid`=1 and `m_tready`=0. `m_tvalid` never drops without a handshake.
- `s_tready` is low for the whole of SEND and PAD. Input is never accepted in the same cycle as an output handshake.
- `m_tready` asserted in the same cycle `m_tvalid` rises: the handshake completes that cycle, and FILL (or PAD) applies next cycle.
- `reset` asserted mid-fill or mid-send:
  - Discard the partial block and any pending pad.
  - Drop `m_tvalid` the next cycle; emit no partial output.
- `err` sets in the cycle after the offending handshake.

## Test plan
- 16-byte message 000102..0F (4 beats, `s_tkeep`=1111, last on beat 4), PAD_ENABLE=1, `m_tready`=1:
  - Block 1: `m_tdata`=0x000102030405060708090A0B0C0D0E0F, tlast=0.
  - Block 2: `m_tdata`=0x10101010101010101010101010101010, tlast=1.
- 5-byte message, PAD_ENABLE=1:
  - Beats: 0x00112233/1111, then 0x44xxxxxx/1000 with last.
  - One block: 0x00112233440B0B0B0B0B0B0B0B0B0B0B, tlast=1.
- Same two stimuli with PAD_ENABLE=0:
  - 5-byte: 0x00112233440000000000000000000000, tlast=1.
  - 16-byte: a single block, tlast=1, and no pad block.
- Backpressure: `m_tready`=0 for 10 cycles with a block pending.
  - `m_tdata`/`m_tlast` constant, `s_tready`=0, no input beat lost.
  - The next block is correct after release.
- Reset pulse after 2 of 4 beats, then a fresh 8-byte message 0xAABBCCDD, 0xEEFF0011 (last):
  - Output 0xAABBCCDDEEFF00110808080808080808, tlast=1.
  - No residue from the aborted message.
- Non-last beat with `s_tkeep`=0101:
  - `err`=1 next cycle and remains 1.
  - The beat is packed as 4 bytes.
  - `err` clears only on `reset`.

Source files
------------

// File: rtl/aes_block_packer.sv
// Packs a byte-oriented 32-bit stream into 128-bit AES blocks and pads the final
// block (PKCS#7 or zero-fill) ahead of the encryption core.
module aes_block_packer #(
  parameter bit PAD_ENABLE = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [31:0]  s_tdata,
  input  logic [3:0]   s_tkeep,
  input  logic         s_tvalid,
  input  logic         s_tlast,
  output logic         s_tready,
  output logic [127:0] m_tdata,
  output logic         m_tvalid,
  output logic         m_tlast,
  input  logic         m_tready,
  output logic         err
);

  localparam int unsigned BLK_W  = 128;
  localparam int unsigned BEAT_W = 32;
  localparam int unsigned CNT_W  = 5;

  typedef enum logic [1:0] {ST_FILL, ST_SEND, ST_PAD} state_t;

  state_t             r_state, w_state_nxt;
  logic [BLK_W-1:0]   r_block, w_block_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic               r_pad_pend, w_pad_pend_nxt;
  logic               r_tvalid, w_tvalid_nxt;
  logic               r_tlast, w_tlast_nxt;
  logic               r_err, w_err_nxt;

  logic               w_accept;
  logic               w_keep_ok;
  logic [3:0]         w_keep_eff;
  logic [2:0]         w_nbytes;
  logic [CNT_W-1:0]   w_cnt_sum;
  logic [BEAT_W-1:0]  w_beat_mask;
  logic [BLK_W-1:0]   w_data_sh, w_mask_sh, w_fill_mask;
  logic [7:0]         w_pad_val;

  assign s_tready = (r_state == ST_FILL) && !reset;
  assign w_accept = s_tvalid && s_tready;

  // Legal keep patterns; anything else is flagged and treated as a full beat
  always_comb begin
    w_keep_ok = 1'b0;
    if (s_tlast) begin
      case (s_tkeep)
        4'b1000, 4'b1100, 4'b1110, 4'b1111: w_keep_ok = 1'b1;
        default:                            w_keep_ok = 1'b0;
      endcase
    end else begin
      w_keep_ok = (s_tkeep == 4'b1111);
    end
    w_keep_eff = w_keep_ok ? s_tkeep : 4'b1111;
    case (w_keep_eff)
      4'b1000: w_nbytes = 3'd1;
      4'b1100: w_nbytes = 3'd2;
      4'b1110: w_nbytes = 3'd3;
      default: w_nbytes = 3'd4;
    endcase
  end

  assign w_cnt_sum   = r_cnt + {2'b00, w_nbytes};
  assign w_beat_mask = {{8{w_keep_eff[3]}}, {8{w_keep_eff[2]}},
                        {8{w_keep_eff[1]}}, {8{w_keep_eff[0]}}};
  // Beats land at byte offset cnt; byte 0 of the block sits in the MSBs
  assign w_data_sh   = {s_tdata & w_beat_mask, 96'd0} >> {r_cnt, 3'b000};
  assign w_mask_sh   = {w_beat_mask, 96'd0} >> {r_cnt, 3'b000};
  assign w_fill_mask = s_tlast ? ({BLK_W{1'b1}} >> {w_cnt_sum, 3'b000}) : '0;
  assign w_pad_val   = PAD_ENABLE ? 8'(5'd16 - w_cnt_sum) : 8'h00;

  // Next-state and registered-output logic
  always_comb begin
    w_state_nxt    = r_state;
    w_block_nxt    = r_block;
    w_cnt_nxt      = r_cnt;
    w_pad_pend_nxt = r_pad_pend;
    w_tvalid_nxt   = r_tvalid;
    w_tlast_nxt    = r_tlast;
    w_err_nxt      = r_err;
    case (r_state)
      ST_FILL: begin
        if (w_accept) begin
          w_err_nxt   = r_err | ~w_keep_ok;
          w_cnt_nxt   = w_cnt_sum;
          w_block_nxt = (r_block & ~w_mask_sh & ~w_fill_mask) | w_data_sh
                      | ({16{w_pad_val}} & w_fill_mask);
          if (s_tlast) begin
            w_state_nxt  = ST_SEND;
            w_tvalid_nxt = 1'b1;
            if ((w_cnt_sum == 5'd16) && PAD_ENABLE) begin
              w_tlast_nxt    = 1'b0;
              w_pad_pend_nxt = 1'b1;
            end else begin
              w_tlast_nxt = 1'b1;
            end
          end else if (w_cnt_sum == 5'd16) begin
            w_state_nxt  = ST_SEND;
            w_tvalid_nxt = 1'b1;
            w_tlast_nxt  = 1'b0;
          end
        end
      end
      ST_SEND: begin
        if (m_tready) begin
          if (r_pad_pend) begin
            w_state_nxt = ST_PAD;
            w_block_nxt = {16{8'h10}};
            w_tlast_nxt = 1'b1;
          end else begin
            w_state_nxt  = ST_FILL;
            w_cnt_nxt    = '0;
            w_block_nxt  = '0;
            w_tvalid_nxt = 1'b0;
            w_tlast_nxt  = 1'b0;
          end
        end
      end
      ST_PAD: begin
        if (m_tready) begin
          w_state_nxt    = ST_FILL;
          w_pad_pend_nxt = 1'b0;
          w_cnt_nxt      = '0;
          w_block_nxt    = '0;
          w_tvalid_nxt   = 1'b0;
          w_tlast_nxt    = 1'b0;
        end
      end
      default: w_state_nxt = ST_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_FILL;
      r_block    <= '0;
      r_cnt      <= '0;
      r_pad_pend <= 1'b0;
      r_tvalid   <= 1'b0;
      r_tlast    <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_block    <= w_block_nxt;
      r_cnt      <= w_cnt_nxt;
      r_pad_pend <= w_pad_pend_nxt;
      r_tvalid   <= w_tvalid_nxt;
      r_tlast    <= w_tlast_nxt;
      r_err      <= w_err_nxt;
    end
  end

  assign m_tdata  = r_block;
  assign m_tvalid = r_tvalid;
  assign m_tlast  = r_tlast;
  assign err      = r_err;

endmodule

// File: tb/tb_aes_block_packer.sv
// Directed bench for aes_block_packer: one padded and one zero-fill instance,
// selected through a shared stimulus bus.
module tb_aes_block_packer;

  logic         clk = 1'b0;
  logic         reset;
  logic         sel;
  logic [31:0]  s_tdata;
  logic [3:0]   s_tkeep;
  logic         s_tvalid;
  logic         s_tlast;
  logic         m_tready;

  logic         a_s_tready, b_s_tready;
  logic [127:0] a_m_tdata, b_m_tdata;
  logic         a_m_tvalid, b_m_tvalid;
  logic         a_m_tlast, b_m_tlast;
  logic         a_err, b_err;

  logic         s_tready, m_tvalid, m_tlast, err;
  logic [127:0] m_tdata;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  aes_block_packer #(.PAD_ENABLE(1'b1)) dut_pad (
    .clk(clk), .reset(reset),
    .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tvalid(s_tvalid && !sel),
    .s_tlast(s_tlast), .s_tready(a_s_tready),
    .m_tdata(a_m_tdata), .m_tvalid(a_m_tvalid), .m_tlast(a_m_tlast),
    .m_tready(m_tready), .err(a_err)
  );

  aes_block_packer #(.PAD_ENABLE(1'b0)) dut_nopad (
    .clk(clk), .reset(reset),
    .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tvalid(s_tvalid && sel),
    .s_tlast(s_tlast), .s_tready(b_s_tready),
    .m_tdata(b_m_tdata), .m_tvalid(b_m_tvalid), .m_tlast(b_m_tlast),
    .m_tready(m_tready), .err(b_err)
  );

  assign s_tready = sel ? b_s_tready : a_s_tready;
  assign m_tdata  = sel ? b_m_tdata  : a_m_tdata;
  assign m_tvalid = sel ? b_m_tvalid : a_m_tvalid;
  assign m_tlast  = sel ? b_m_tlast  : a_m_tlast;
  assign err      = sel ? b_err      : a_err;

  // All tasks run in the phase 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    bit acc;
    acc = 1'b0;
    s_tdata  = d;
    s_tkeep  = k;
    s_tlast  = l;
    s_tvalid = 1'b1;
    for (int c = 0; c < 50 && !acc; c++) begin
      acc = s_tready;
      tick();
    end
    s_tvalid = 1'b0;
    n_vec++;
    if (!acc) begin
      n_err++;
      $display("FAIL beat_accept: beat %h not accepted within 50 cycles", d);
    end
  endtask

  task automatic wait_valid();
    for (int c = 0; c < 20 && !m_tvalid; c++) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; sel = 1'b0; m_tready = 1'b1;
    s_tvalid = 1'b0; s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0;
    repeat (3) tick();
    n_vec++;
    if ({a_s_tready, a_m_tvalid, a_m_tlast, a_err, a_m_tdata,
         b_s_tready, b_m_tvalid, b_m_tlast, b_err, b_m_tdata} !== '0) begin
      n_err++;
      $display("FAIL reset_state: got a=%b%b%b%b %h b=%b%b%b%b %h, required all zero",
               a_s_tready, a_m_tvalid, a_m_tlast, a_err, a_m_tdata,
               b_s_tready, b_m_tvalid, b_m_tlast, b_err, b_m_tdata);
    end
    reset = 1'b0;
    #1;
    n_vec++;
    if ({a_s_tready, b_s_tready, a_m_tvalid} !== 3'b110) begin
      n_err++;
      $display("FAIL reset_release: got tready a=%b b=%b tvalid=%b, required 1 1 0",
               a_s_tready, b_s_tready, a_m_tvalid);
    end
    tick();
  endtask

  task automatic test_pad_full16();
    sel = 1'b0;
    send_beat(32'h00010203, 4'b1111, 1'b0);
    send_beat(32'h04050607, 4'b1111, 1'b0);
    send_beat(32'h08090A0B, 4'b1111, 1'b0);
    send_beat(32'h0C0D0E0F, 4'b1111, 1'b1);
    n_vec++;
    if (m_tvalid !== 1'b1) begin
      n_err++;
      $display("FAIL full16_latency: m_tvalid=%b one cycle after last beat, required 1", m_tvalid);
    end
    wait_valid();
    n_vec++;
    if ({m_tvalid, m_tlast, s_tready, m_tdata} !==
        {3'b100, 128'h000102030405060708090A0B0C0D0E0F}) begin
      n_err++;
      $display("FAIL full16_block: got v=%b l=%b rdy=%b %h, required v=1 l=0 rdy=0 000102030405060708090a0b0c0d0e0f",
               m_tvalid, m_tlast, s_tready, m_tdata);
    end
    tick();
    wait_valid();
    n_vec++;
    if ({m_tvalid, m_tlast, s_tready, m_tdata} !== {3'b110, {16{8'h10}}}) begin
      n_err++;
      $display("FAIL full16_pad: got v=%b l=%b rdy=%b %h, required v=1 l=1 rdy=0 10 x16",
               m_tvalid, m_tlast, s_tready, m_tdata);
    end
    tick();
    n_vec++;
    if ({m_tvalid, s_tready} !== 2'b01) begin
      n_err++;
      $display("FAIL full16_idle: got v=%b rdy=%b, required v=0 rdy=1", m_tvalid, s_tready);
    end
  endtask

  task automatic test_pad_short5();
    sel = 1'b0;
    send_beat(32'h00112233, 4'b1111, 1'b0);
    send_beat(32'h44DEADBE, 4'b1000, 1'b1);
    wait_valid();
    n_vec++;
    if ({m_tvalid, m_tlast, m_tdata} !== {2'b11, 128'h00112233440B0B0B0B0B0B0B0B0B0B0B}) begin
      n_err++;
      $display("FAIL short5_pad: got v=%b l=%b %h, required v=1 l=1 00112233440b0b0b0b0b0b0b0b0b0b0b",
               m_tvalid, m_tlast, m_tdata);
    end
    tick();
  endtask

  task automatic test_nopad();
    bit seen;
    sel = 1'b1;
    send_beat(32'h00112233, 4'b1111, 1'b0);
    send_beat(32'h44DEADBE, 4'b1000, 1'b1);
    wait_valid();
    n_vec++;
    if ({m_tvalid, m_tlast, m_tdata} !== {2'b11, 128'h00112233440000000000000000000000}) begin
      n_err++;
      $display("FAIL nopad_short5: got v=%b l=%b %h, required v=1 l=1 00112233440000000000000000000000",
               m_tvalid, m_tlast, m_tdata);
    end
    tick();
    send_beat(32'h00010203, 4'b1111, 1'b0);
    send_beat(32'h04050607, 4'b1111, 1'b0);
    send_beat(32'h08090A0B, 4'b1111, 1'b0);
    send_beat(32'h0C0D0E0F, 4'b1111, 1'b1);
    wait_valid();
    n_vec++;
    if ({m_tvalid, m_tlast, m_tdata} !== {2'b11, 128'h000102030405060708090A0B0C0D0E0F}) begin
      n_err++;
      $display("FAIL nopad_full16: got v=%b l=%b %h, required v=1 l=1 000102030405060708090a0b0c0d0e0f",
               m_tvalid, m_tlast, m_tdata);
    end
    tick();
    seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      seen |= m_tvalid;
      tick();
    end
    n_vec++;
    if (seen !== 1'b0) begin
      n_err++;
      $display("FAIL nopad_no_extra: got an extra block (m_tvalid=1), required none");
    end
    sel = 1'b0;
  endtask

  task automatic test_backpressure();
    bit bad;
    sel = 1'b0;
    m_tready = 1'b0;
    send_beat(32'h11223344, 4'b1111, 1'b0);
    send_beat(32'h55667788, 4'b1111, 1'b1);
    s_tdata = 32'hA0A1A2A3; s_tkeep = 4'b1111; s_tlast = 1'b0; s_tvalid = 1'b1;
    bad = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (m_tvalid !== 1'b1 || m_tlast !== 1'b1 || s_tready !== 1'b0 ||
          m_tdata !== 128'h11223344556677880808080808080808) bad = 1'b1;
      tick();
    end
    n_vec++;
    if (bad) begin
      n_err++;
      $display("FAIL bp_hold: output changed or s_tready rose under backpressure (now v=%b l=%b rdy=%b %h)",
               m_tvalid, m_tlast, s_tready, m_tdata);
    end
    m_tready = 1'b1;
    n_vec++;
    if ({m_tvalid, m_tlast, m_tdata} !== {2'b11, 128'h11223344556677880808080808080808}) begin
      n_err++;
      $display("FAIL bp_block: got v=%b l=%b %h, required v=1 l=1 11223344556677880808080808080808",
               m_tvalid, m_tlast, m_tdata);
    end
    tick();
    send_beat(32'hA0A1A2A3, 4'b1111, 1'b0);
    send_beat(32'hA4A5A6A7, 4'b1111, 1'b0);
    send_beat(32'hA8A9AAAB, 4'b1111, 1'b0);
    send_beat(32'hACADAEAF, 4'b1111, 1'b1);
    wait_valid();
    n_vec++;
    if ({m_tvalid, m_tlast, m_tdata} !== {2'b10, 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF}) begin
      n_err++;
      $display("FAIL bp_next_block: got v=%b l=%b %h, required v=1 l=0 a0a1a2a3a4a5a6a7a8a9aaabacadaeaf",
               m_tvalid, m_tlast, m_tdata);
    end
    tick();
    wait_valid();
    n_vec++;
    if ({m_tvalid, m_tlast, m_tdata} !== {2'b11, {16{8'h10}}}) begin
      n_err++;
      $display("FAIL bp_next_pad: got v=%b l=%b %h, required v=1 l=1 10 x16",
               m_tvalid, m_tlast, m_tdata);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    bit seen;
    sel = 1'b0;
    send_beat(32'hDEADBEEF, 4'b1111, 1'b0);
    send_beat(32'h12345678, 4'b1111, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    n_vec++;
    if ({m_tvalid, s_tready} !== 2'b01) begin
      n_err++;
      $display("FAIL rstfill_state: got v=%b rdy=%b, required v=0 rdy=1", m_tvalid, s_tready);
    end
    send_beat(32'hAABBCCDD, 4'b1111, 1'b0);
    send_beat(32'hEEFF0011, 4'b1111, 1'b1);
    wait_valid();
    n_vec++;
    if ({m_tvalid, m_tlast, m_tdata} !== {2'b11, 128'hAABBCCDDEEFF00110808080808080808}) begin
      n_err++;
      $display("FAIL rstfill_block: got v=%b l=%b %h, required v=1 l=1 aabbccddeeff00110808080808080808",
               m_tvalid, m_tlast, m_tdata);
    end
    tick();
    m_tready = 1'b0;
    send_beat(32'h01020304, 4'b1000, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_tready = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 3; c++) begin
      seen |= m_tvalid;
      if (m_tdata !== '0) seen = 1'b1;
      tick();
    end
    n_vec++;
    if (seen !== 1'b0) begin
      n_err++;
      $display("FAIL rstsend_drop: output still valid or data nonzero after reset (v=%b %h), required v=0 data 0",
               m_tvalid, m_tdata);
    end
  endtask

  task automatic test_err();
    sel = 1'b0;
    n_vec++;
    if (err !== 1'b0) begin
      n_err++;
      $display("FAIL err_initial: got %b, required 0", err);
    end
    send_beat(32'h01020304, 4'b0101, 1'b0);
    n_vec++;
    if (err !== 1'b1) begin
      n_err++;
      $display("FAIL err_set: got %b one cycle after bad keep, required 1", err);
    end
    send_beat(32'h05060708, 4'b1111, 1'b0);
    send_beat(32'h090A0B0C, 4'b1111, 1'b0);
    send_beat(32'h0D0E0F10, 4'b1111, 1'b1);
    wait_valid();
    n_vec++;
    if ({m_tvalid, m_tlast, m_tdata} !== {2'b10, 128'h0102030405060708090A0B0C0D0E0F10}) begin
      n_err++;
      $display("FAIL err_block: got v=%b l=%b %h, required v=1 l=0 0102030405060708090a0b0c0d0e0f10",
               m_tvalid, m_tlast, m_tdata);
    end
    tick();
    wait_valid();
    tick();
    n_vec++;
    if (err !== 1'b1) begin
      n_err++;
      $display("FAIL err_sticky: got %b after message, required 1", err);
    end
    reset = 1'b1;
    tick();
    n_vec++;
    if (err !== 1'b0) begin
      n_err++;
      $display("FAIL err_clear: got %b after reset, required 0", err);
    end
    reset = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_pad_full16();
    test_pad_short5();
    test_nopad();
    test_backpressure();
    test_reset_mid();
    test_err();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
